// File: rtl/mmlc_pkg.sv
// Shared types for the multi-mode limit counter: FSM states and limit update direction.
package mmlc_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    SHRINK = 1'b0,
    GROW   = 1'b1
  } mode_e;

endpackage

// File: rtl/mmlc_limit_step.sv
// Combinational per-pass limit update: computes the next terminal count and flags
// the pass that ends the sequence.
module mmlc_limit_step
  import mmlc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur_limit,
  input  logic [WIDTH-1:0] step,
  input  mode_e            mode,
  output logic [WIDTH-1:0] next_limit,
  output logic             terminal
);

  logic [WIDTH:0] sum_s;

  // The extra sum bit flags a grow result above the largest WIDTH-bit value.
  always_comb begin
    sum_s      = {1'b0, cur_limit} + {1'b0, step};
    next_limit = cur_limit;
    terminal   = 1'b0;
    case (mode)
      GROW: begin
        terminal   = sum_s[WIDTH];
        next_limit = sum_s[WIDTH-1:0];
      end
      SHRINK: begin
        terminal   = (cur_limit <= step);
        next_limit = cur_limit - step;
      end
      default: begin
        terminal   = 1'b1;
        next_limit = cur_limit;
      end
    endcase
  end

endmodule

// File: rtl/multi_mode_limit_counter.sv
// Up-counter whose terminal count shrinks or grows by a step after each pass,
// with pause, abort, auto-reload and pass/sequence completion strobes.
module multi_mode_limit_counter
  import mmlc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             mode,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit_init,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] cur_limit,
  output logic             busy,
  output logic             pass_done,
  output logic             seq_done,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cur_limit_q, cur_limit_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             pass_done_q, pass_done_d;
  logic             seq_done_q, seq_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic [WIDTH-1:0] next_limit_s;
  logic             terminal_s;

  mmlc_limit_step #(.WIDTH(WIDTH)) u_limit_step (
    .cur_limit  (cur_limit_q),
    .step       (step_q),
    .mode       (mode_q),
    .next_limit (next_limit_s),
    .terminal   (terminal_s)
  );

  // Next-state logic: stop outranks everything but reset; pulses default low.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    count_d     = count_q;
    cur_limit_d = cur_limit_q;
    init_d      = init_q;
    step_d      = step_q;
    reload_d    = reload_q;
    pass_done_d = 1'b0;
    seq_done_d  = 1'b0;
    cfg_err_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = {WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          count_d = {WIDTH{1'b0}};
          if (start) begin
            if ((limit_init == {WIDTH{1'b0}}) || (step == {WIDTH{1'b0}})) begin
              cfg_err_d = 1'b1;
            end else begin
              state_d     = RUN;
              init_d      = limit_init;
              step_d      = step;
              mode_d      = mode_e'(mode);
              reload_d    = auto_reload;
              cur_limit_d = limit_init;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (en) begin
            if (count_q < cur_limit_q) begin
              count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
              count_d     = {WIDTH{1'b0}};
              pass_done_d = 1'b1;
              if (terminal_s) begin
                seq_done_d = 1'b1;
                if (reload_q) begin
                  cur_limit_d = init_q;
                end else begin
                  state_d = IDLE;
                end
              end else begin
                cur_limit_d = next_limit_s;
              end
            end
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = {WIDTH{1'b0}};
        end
      endcase
    end
    busy_d = (state_d == RUN);
  end

  // State, configuration and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= SHRINK;
      count_q     <= {WIDTH{1'b0}};
      cur_limit_q <= {WIDTH{1'b0}};
      init_q      <= {WIDTH{1'b0}};
      step_q      <= {WIDTH{1'b0}};
      reload_q    <= 1'b0;
      busy_q      <= 1'b0;
      pass_done_q <= 1'b0;
      seq_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      cur_limit_q <= cur_limit_d;
      init_q      <= init_d;
      step_q      <= step_d;
      reload_q    <= reload_d;
      busy_q      <= busy_d;
      pass_done_q <= pass_done_d;
      seq_done_q  <= seq_done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign count     = count_q;
  assign cur_limit = cur_limit_q;
  assign busy      = busy_q;
  assign pass_done = pass_done_q;
  assign seq_done  = seq_done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: doc/multi_mode_limit_counter.md
# multi_mode_limit_counter

Parametrised up-counter whose terminal count changes by a programmable step after every completed pass. It shrinks or grows the limit until the sequence is exhausted, then optionally reloads. It generalises the team's fixed 4-bit decrementing counter with these additions:
- width parameter
- loadable initial limit and step
- grow mode
- pause, abort and auto-reload
- pass/sequence completion strobes

It serves as a pattern/timing generator in test fixtures and as a burst-length sequencer.

## Interface
- WIDTH, 4: bit width of count, limit and step.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin a sequence. Honoured only in IDLE.
- stop  in  1  abort. Returns the block to IDLE from any state.
- en  in  1  count enable. When low in RUN, all state holds.
- mode  in  1  0 = shrink (limit -= step per pass), 1 = grow (limit += step per pass). Sampled at start.
- auto_reload  in  1  1 = restart from limit_init after the sequence ends. Sampled at start.
- limit_init  in  WIDTH  first-pass terminal count. Sampled at start.
- step  in  WIDTH  limit change per pass. Sampled at start.
- count  out  WIDTH  current count.
- cur_limit  out  WIDTH  terminal count of the current pass.
- busy  out  1  high in RUN.
- pass_done  out  1  one-cycle pulse on the cycle count wraps to 0.
- seq_done  out  1  one-cycle pulse on the wrap that ends the sequence.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, RUN. Reset puts the block in IDLE.
- Reset values: every output is 0.
- IDLE
  - count = 0 and busy = 0.
  - Start is rejected if limit_init == 0 or step == 0. The block pulses cfg_err and stays in IDLE.
  - Otherwise it latches limit_init, step, mode and auto_reload, sets cur_limit = limit_init and count = 0, and goes to RUN.
- RUN with en = 1
  - If count < cur_limit: count increments by 1.
  - If count == cur_limit: count goes to 0, pass_done pulses, and the limit update below is applied.
- Limit update, evaluated with the current cur_limit and the latched step, using WIDTH+1-bit arithmetic:
  - Shrink: terminal when cur_limit <= step. Otherwise cur_limit becomes cur_limit - step.
  - Grow: terminal when cur_limit + step > 2^WIDTH - 1. Otherwise cur_limit becomes cur_limit + step.
- Terminal wrap
  - seq_done pulses together with pass_done.
  - If auto_reload = 1: cur_limit reloads from the latched init value and the block stays in RUN.
  - If auto_reload = 0: the block goes to IDLE and cur_limit holds its last value.
- RUN with en = 0: count, cur_limit and state hold. No pulses.
- start while in RUN is ignored: no cfg_err, and the latched configuration is unchanged.
- stop has priority over en and start. On stop, next cycle shows IDLE, count = 0, busy = 0, no pulses.
- rst has priority over everything.
- Each pass lasts cur_limit + 1 enabled cycles, covering count 0 through cur_limit. The limit is never 0 in RUN.

## Timing
- All outputs are registered.
- Start accepted at edge N: busy = 1 and count = 0 after N. The first increment happens at edge N+1 if en = 1.
- pass_done and seq_done are high for exactly the cycle after the wrap edge, when count = 0. cur_limit already shows the new value in that cycle.
- Pulses never repeat while en = 0.
- Terminal wrap without reload:
  - busy drops in the same cycle seq_done is high.
  - A start in that cycle is accepted, because the state is already IDLE.
- Reset mid-run: the next cycle shows all outputs 0 and IDLE. The latched configuration is discarded.

## Structure
- Package mmlc_pkg holds:
  - typedef enum state_e {IDLE, RUN}
  - typedef enum mode_e {SHRINK, GROW}
- Sub-module mmlc_limit_step is combinational. It takes cur_limit, step and mode, and outputs next_limit and terminal. It is verified standalone.
- The top holds the FSM, counter, configuration latches and pulse registers.

## Test plan
- Shrink: WIDTH=4, init 15, step 1, no reload.
  - Pass lengths are 16, 15, …, 2 enabled cycles: 15 pass_done pulses in total.
  - seq_done arrives 135 enabled cycles after start, then IDLE with cur_limit = 1.
- Grow: init 3, step 4.
  - cur_limit sequence is 3, 7, 11, 15.
  - seq_done arrives after 40 enabled cycles.
  - With auto_reload = 1, the next pass uses cur_limit = 3 and busy stays 1.
- Enable gaps: random en toggling during shrink 9/step 2.
  - count never changes while en = 0.
  - Pass lengths are 10, 8, 6, 4, 2 enabled cycles.
- Rejects and ignored starts:
  - start with step = 0 → cfg_err pulse, stays IDLE.
  - start with limit_init = 0 → cfg_err pulse, stays IDLE.
  - start during RUN → ignored, configuration unchanged.
- Abort and reset:
  - stop asserted together with en at count = 5 → next cycle count = 0, busy = 0, no pass_done.
  - rst mid-pass → all outputs 0.
- Terminal edge case: WIDTH=4, grow, init 15, step 1.
  - Terminal on the first wrap: seq_done after 16 cycles.
  - No overflow, and cur_limit stays 15.
